// File: rtl/clip_controller_pkg.sv
// Shared types and defaults for the clip record/playback controller.
package clip_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REC  = 2'd1,
        PLAY = 2'd2
    } state_t;

    localparam int SAMPLE_W_DEF = 8;
    localparam int ADDR_W_DEF   = 12;

    // Samples held per clip for a given per-clip address width.
    function automatic int clipDepth(input int addrW);
        return 1 << addrW;
    endfunction

endpackage

// File: rtl/clip_controller_action_edge_detect.sv
// Registered rising-edge detector for a synchronized button level.
module action_edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic levelPrev;

    // Previous-level register; the reset value decides whether a level held high out of reset reads as a rise
    always_ff @(posedge clock) begin
        if (reset) begin
            levelPrev <= RESET_VAL;
        end else begin
            levelPrev <= level;
        end
    end

    assign rise = level & ~levelPrev;

endmodule

// File: rtl/clip_controller.sv
// Record/playback session controller for two clips sharing one sample memory.
module clip_controller
    import clip_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                actionSync,
    input  logic                clipNumSync,
    input  logic                playOrRecordSync,
    input  logic                resetButtonSync,
    input  logic                sampleTick,
    input  logic [SAMPLE_W-1:0] micSample,
    output logic [ADDR_W:0]     memAddr,
    output logic                memWrEn,
    output logic [SAMPLE_W-1:0] memWrData,
    output logic                memRdEn,
    input  logic [SAMPLE_W-1:0] memRdData,
    output logic [SAMPLE_W-1:0] spkSample,
    output logic                spkValid,
    output logic                recording,
    output logic                playing
);

    localparam int              CLIP_DEPTH = clipDepth(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(CLIP_DEPTH - 1);

    state_t            state;
    logic              clip;
    logic [ADDR_W-1:0] pointer;
    logic [ADDR_W:0]   len [2];
    logic              press;
    logic              erase;
    logic              lastRead;
    logic              rdPending_p1;

    // An action level held through reset must not look like a fresh press.
    action_edge_detect #(
        .RESET_VAL(1'b1)
    ) u_actionEdge (
        .clock (clock),
        .reset (reset),
        .level (actionSync),
        .rise  (press)
    );

    assign erase    = resetButtonSync;
    assign lastRead = ({1'b0, pointer} == (len[clip] - 1'b1));

    // Session FSM: clip/pointer bookkeeping, clip lengths and the registered memory strobes
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            clip      <= 1'b0;
            pointer   <= '0;
            len[0]    <= '0;
            len[1]    <= '0;
            memWrEn   <= 1'b0;
            memRdEn   <= 1'b0;
            memAddr   <= '0;
            memWrData <= '0;
        end else begin
            memWrEn <= 1'b0;
            memRdEn <= 1'b0;
            if (erase) begin
                state  <= IDLE;
                len[0] <= '0;
                len[1] <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (press) begin
                            if (playOrRecordSync) begin
                                state            <= REC;
                                clip             <= clipNumSync;
                                pointer          <= '0;
                                len[clipNumSync] <= '0;
                            end else if (len[clipNumSync] != '0) begin
                                state   <= PLAY;
                                clip    <= clipNumSync;
                                pointer <= '0;
                            end
                        end
                    end
                    REC: begin
                        // A tick coinciding with the stopping press is still written.
                        if (sampleTick) begin
                            memWrEn   <= 1'b1;
                            memAddr   <= {clip, pointer};
                            memWrData <= micSample;
                            len[clip] <= {1'b0, pointer} + 1'b1;
                            if (pointer == LAST_PTR) begin
                                state <= IDLE;
                            end else begin
                                pointer <= pointer + 1'b1;
                            end
                        end
                        if (press) begin
                            state <= IDLE;
                        end
                    end
                    PLAY: begin
                        if (sampleTick) begin
                            memRdEn <= 1'b1;
                            memAddr <= {clip, pointer};
                            pointer <= pointer + 1'b1;
                            if (lastRead) begin
                                state <= IDLE;
                            end
                        end
                        if (press) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Read return: p1 marks memRdData valid this cycle, then the sample lands on the speaker; erase kills both
    always_ff @(posedge clock) begin
        if (reset) begin
            rdPending_p1 <= 1'b0;
            spkValid     <= 1'b0;
            spkSample    <= '0;
        end else begin
            rdPending_p1 <= memRdEn & ~erase;
            spkValid     <= rdPending_p1 & ~erase;
            if (rdPending_p1 && !erase) begin
                spkSample <= memRdData;
            end
        end
    end

    assign recording = (state == REC);
    assign playing   = (state == PLAY);

endmodule

// File: tb/tb_clip_controller.sv
// Scoreboard bench for clip_controller with a queue-based clip model.
module tb_clip_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       actionSync;
    logic       clipNumSync;
    logic       playOrRecordSync;
    logic       resetButtonSync;
    logic       sampleTick;
    logic [7:0] micSample;
    logic [4:0] memAddr;
    logic       memWrEn;
    logic [7:0] memWrData;
    logic       memRdEn;
    logic [7:0] memRdData;
    logic [7:0] spkSample;
    logic       spkValid;
    logic       recording;
    logic       playing;

    clip_controller #(
        .SAMPLE_W(8),
        .ADDR_W  (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .actionSync       (actionSync),
        .clipNumSync      (clipNumSync),
        .playOrRecordSync (playOrRecordSync),
        .resetButtonSync  (resetButtonSync),
        .sampleTick       (sampleTick),
        .micSample        (micSample),
        .memAddr          (memAddr),
        .memWrEn          (memWrEn),
        .memWrData        (memWrData),
        .memRdEn          (memRdEn),
        .memRdData        (memRdData),
        .spkSample        (spkSample),
        .spkValid         (spkValid),
        .recording        (recording),
        .playing          (playing)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Sample memory: read data valid the cycle after memRdEn, junk otherwise.
    logic [7:0] mem [32];
    always @(posedge clock) begin
        if (memWrEn) mem[memAddr] <= memWrData;
        if (memRdEn) memRdData <= mem[memAddr];
        else         memRdData <= 8'($urandom);
    end

    typedef struct {
        int         due;
        logic [4:0] addr;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        int   due;
        logic rec;
        logic play;
    } flg_t;

    exp_t wrQ[$];
    exp_t rdQ[$];
    exp_t spkQ[$];
    flg_t flgQ[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic ok, input int actual, input int required);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, required);
        end
    endtask

    // Reference model: mode 0 idle, 1 recording, 2 playing; clips are stored sample lists.
    int         mMode;
    logic       mClip;
    int         mIdx;
    int         mLen [2];
    logic [7:0] mStore [2][16];
    logic       mPrev;

    task automatic modelStep(input int n);
        logic pr;
        exp_t keep[$];
        if (reset) begin
            mPrev = 1'b1;
            mMode = 0;
            mLen[0] = 0;
            mLen[1] = 0;
            flgQ.push_back('{n + 1, 1'b0, 1'b0});
            return;
        end
        pr    = actionSync && !mPrev;
        mPrev = actionSync;
        if (resetButtonSync) begin
            foreach (spkQ[i]) begin
                if (spkQ[i].due > n + 2) keep.push_back(spkQ[i]);
                else if (spkQ[i].due <= n) keep.push_back(spkQ[i]);
            end
            spkQ = keep;
            mLen[0] = 0;
            mLen[1] = 0;
            mMode = 0;
        end else begin
            case (mMode)
                0: begin
                    if (pr) begin
                        if (playOrRecordSync) begin
                            mMode = 1;
                            mClip = clipNumSync;
                            mLen[mClip] = 0;
                        end else if (mLen[clipNumSync] > 0) begin
                            mMode = 2;
                            mClip = clipNumSync;
                            mIdx = 0;
                        end
                    end
                end
                1: begin
                    if (sampleTick) begin
                        wrQ.push_back('{n + 1, {mClip, 4'(mLen[mClip])}, micSample});
                        mStore[mClip][4'(mLen[mClip])] = micSample;
                        mLen[mClip] = mLen[mClip] + 1;
                        if (mLen[mClip] == 16) mMode = 0;
                    end
                    if (pr) mMode = 0;
                end
                default: begin
                    if (sampleTick) begin
                        rdQ.push_back('{n + 1, {mClip, 4'(mIdx)}, 8'h00});
                        spkQ.push_back('{n + 3, 5'd0, mStore[mClip][4'(mIdx)]});
                        mIdx = mIdx + 1;
                        if (mIdx == mLen[mClip]) mMode = 0;
                    end
                    if (pr) mMode = 0;
                end
            endcase
        end
        flgQ.push_back('{n + 1, mMode == 1, mMode == 2});
    endtask

    // Monitor: pops expectations whenever the DUT presents a strobe, just after each active edge.
    always @(posedge clock) begin
        exp_t e;
        flg_t f;
        #1;
        while (wrQ.size() > 0 && wrQ[0].due < cyc) begin
            e = wrQ.pop_front();
            chk("wr_missing", 1'b0, 0, int'(e.addr));
        end
        while (rdQ.size() > 0 && rdQ[0].due < cyc) begin
            e = rdQ.pop_front();
            chk("rd_missing", 1'b0, 0, int'(e.addr));
        end
        while (spkQ.size() > 0 && spkQ[0].due < cyc) begin
            e = spkQ.pop_front();
            chk("spk_missing", 1'b0, 0, int'(e.data));
        end
        if (memWrEn) begin
            if (wrQ.size() > 0 && wrQ[0].due == cyc) begin
                e = wrQ.pop_front();
                chk("wr_addr", memAddr == e.addr, int'(memAddr), int'(e.addr));
                chk("wr_data", memWrData == e.data, int'(memWrData), int'(e.data));
            end else begin
                chk("wr_unexpected", 1'b0, int'(memAddr), 0);
            end
        end
        if (memRdEn) begin
            if (rdQ.size() > 0 && rdQ[0].due == cyc) begin
                e = rdQ.pop_front();
                chk("rd_addr", memAddr == e.addr, int'(memAddr), int'(e.addr));
            end else begin
                chk("rd_unexpected", 1'b0, int'(memAddr), 0);
            end
        end
        if (spkValid) begin
            if (spkQ.size() > 0 && spkQ[0].due == cyc) begin
                e = spkQ.pop_front();
                chk("spk_data", spkSample == e.data, int'(spkSample), int'(e.data));
            end else begin
                chk("spk_unexpected", 1'b0, int'(spkSample), 0);
            end
        end
        if (memWrEn || memRdEn) begin
            chk("strobe_exclusive", !(memWrEn && memRdEn), int'({memWrEn, memRdEn}), 0);
        end
        while (flgQ.size() > 0 && flgQ[0].due < cyc) f = flgQ.pop_front();
        if (flgQ.size() > 0 && flgQ[0].due == cyc) begin
            f = flgQ.pop_front();
            chk("flags", (recording == f.rec) && (playing == f.play),
                int'({recording, playing}), int'({f.rec, f.play}));
        end
    end

    task automatic step();
        modelStep(cyc);
        @(negedge clock);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic doTick(input logic [7:0] m, input int gap);
        sampleTick = 1'b1;
        micSample  = m;
        step();
        sampleTick = 1'b0;
        micSample  = 8'($urandom);
        idle(gap - 1);
    endtask

    task automatic pressBtn(input logic recMode, input logic c);
        playOrRecordSync = recMode;
        clipNumSync      = c;
        actionSync       = 1'b1;
        step();
        actionSync = 1'b0;
        step();
    endtask

    initial begin
        int gapLeft;
        reset            = 1'b1;
        actionSync       = 1'b1;
        clipNumSync      = 1'b0;
        playOrRecordSync = 1'b1;
        resetButtonSync  = 1'b0;
        sampleTick       = 1'b0;
        micSample        = 8'h00;
        @(negedge clock);
        idle(3);
        reset = 1'b0;

        // Button held through reset: no session while it stays high.
        doTick(8'h77, 4);
        actionSync = 1'b0;
        idle(2);

        // Empty play after reset is a no-op.
        pressBtn(1'b0, 1'b0);
        doTick(8'h44, 6);

        // Record three samples on clip 0, stop, then play them back.
        pressBtn(1'b1, 1'b0);
        idle(3);
        doTick(8'h11, 8);
        doTick(8'h22, 8);
        doTick(8'h33, 8);
        pressBtn(1'b0, 1'b0);
        idle(4);
        pressBtn(1'b0, 1'b0);
        idle(2);
        for (int i = 0; i < 4; i++) doTick(8'($urandom), 8);
        idle(4);

        // Full clip: 20 ticks on clip 1, only 16 written.
        pressBtn(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) doTick(8'($urandom), 8);

        // Press together with a tick while recording.
        pressBtn(1'b1, 1'b0);
        doTick(8'hA1, 8);
        doTick(8'hB2, 8);
        actionSync = 1'b1;
        sampleTick = 1'b1;
        micSample  = 8'h5A;
        step();
        actionSync = 1'b0;
        sampleTick = 1'b0;
        idle(8);
        pressBtn(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) doTick(8'($urandom), 8);

        // Erase the cycle after a read strobe during playback of clip 1.
        pressBtn(1'b0, 1'b1);
        idle(2);
        doTick(8'h00, 8);
        sampleTick = 1'b1;
        step();
        sampleTick = 1'b0;
        step();
        resetButtonSync = 1'b1;
        step();
        resetButtonSync = 1'b0;
        idle(6);
        pressBtn(1'b0, 1'b1);
        doTick(8'h00, 6);
        pressBtn(1'b0, 1'b0);
        doTick(8'h00, 6);

        // Random traffic against the model.
        gapLeft = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) actionSync = ~actionSync;
            clipNumSync      = 1'($urandom_range(0, 1));
            playOrRecordSync = 1'($urandom_range(0, 1));
            resetButtonSync  = ($urandom_range(0, 299) == 0);
            if (gapLeft == 0 && $urandom_range(0, 2) == 0) begin
                sampleTick = 1'b1;
                gapLeft    = int'($urandom_range(4, 9));
            end else begin
                sampleTick = 1'b0;
            end
            if (gapLeft > 0) gapLeft--;
            micSample = 8'($urandom);
            step();
        end
        actionSync      = 1'b0;
        resetButtonSync = 1'b0;
        sampleTick      = 1'b0;
        idle(12);

        chk("wr_queue_drained", wrQ.size() == 0, wrQ.size(), 0);
        chk("rd_queue_drained", rdQ.size() == 0, rdQ.size(), 0);
        chk("spk_queue_drained", spkQ.size() == 0, spkQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
